// File: rtl/fetch_queue_stage_pkg.sv
// Shared constants for the prefetching fetch stage: halt opcode, reset PC
// default and the layout of one prefetch-queue entry.
package fetch_queue_stage_pkg;

    localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;
    localparam int         RESET_PC_DEF    = 0;

    // Queue entry is {pc, instr}: PC in the upper WIDTH bits, instruction below.
    localparam int ENTRY_FIELDS = 2;

    function automatic int entry_width(input int width);
        return ENTRY_FIELDS * width;
    endfunction

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Bundle of the fetch stage's memory handshake, redirect input and decode-side
// output. master = fetch stage, slave = surrounding pipeline/memory.
interface fetch_queue_stage_if #(
    parameter int WIDTH = 16
);
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_resp_valid;
    logic [WIDTH-1:0] imem_resp_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_instr;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_pc_plus2;
    logic             halted;

    modport master (
        input  redirect, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
               out_pc_plus2, halted
    );

    modport slave (
        output redirect, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
               out_pc_plus2, halted
    );
endinterface

// File: rtl/fetch_queue_stage_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// Flush (and reset) win over push/pop in the same cycle.
module fetch_fifo #(
    parameter  int WIDTH_DATA = 32,
    parameter  int DEPTH      = 4,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH_DATA-1:0] push_data,
    input  logic                  pop,
    output logic [WIDTH_DATA-1:0] head,
    output logic [CW-1:0]         count
);
    localparam int AW = CW - 1;

    logic [DEPTH-1:0][WIDTH_DATA-1:0] mem;
    logic [AW-1:0]                    wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_stage.sv
// Prefetching fetch stage: one outstanding imem request feeding a DEPTH-entry
// {pc, instr} queue, with redirect flush/discard and halt detection.
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(RESET_PC_DEF),
    parameter logic [3:0]       HALT_OPCODE = HALT_OPCODE_DEF
) (
    input logic                clk,
    input logic                rst,
    fetch_queue_stage_if.master bus
);
    localparam int EW = entry_width(WIDTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] fetch_pc, req_pc;
    logic             outstanding, discard, halt_seen;
    logic [CW-1:0]    count;
    logic [EW-1:0]    head;
    logic             issue, accept, resp, push, pop, is_halt, out_valid;

    // Only issue with no request in flight, so count<DEPTH already reserves
    // the slot the response will land in.
    assign issue   = ~rst & ~halt_seen & ~outstanding & ~bus.redirect &
                     (count < CW'(DEPTH));
    assign accept  = issue & bus.imem_req_ready;
    assign resp    = bus.imem_resp_valid & outstanding;
    assign is_halt = bus.imem_resp_data[WIDTH-1 -: 4] == HALT_OPCODE;
    assign push    = resp & ~discard & ~bus.redirect;
    assign out_valid = ~rst & (count != '0);
    assign pop     = out_valid & bus.out_ready;

    fetch_fifo #(
        .WIDTH_DATA (EW),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .push      (push),
        .push_data ({req_pc, bus.imem_resp_data}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            halt_seen   <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc  <= bus.redirect_pc;
            halt_seen <= 1'b0;
            // A response landing now is simply dropped; otherwise mark the
            // in-flight request stale so its later response is thrown away.
            outstanding <= outstanding & ~bus.imem_resp_valid;
            discard     <= outstanding & ~bus.imem_resp_valid;
        end else begin
            if (resp) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
                if (~discard & is_halt) halt_seen <= 1'b1;
            end
            if (accept) begin
                outstanding <= 1'b1;
                req_pc      <= fetch_pc;
                fetch_pc    <= fetch_pc + WIDTH'(2);
            end
        end
    end

    assign bus.imem_req_valid = issue;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.out_valid      = out_valid;
    assign bus.out_pc         = out_valid ? head[EW-1 -: WIDTH] : '0;
    assign bus.out_instr      = out_valid ? head[WIDTH-1:0] : '0;
    assign bus.out_pc_plus2   = bus.out_pc + WIDTH'(2);
    assign bus.halted         = ~rst & halt_seen & ~outstanding;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: directed scenarios plus a random phase, with a
// queue-based model of the stage compared every cycle.
module tb_fetch_queue_stage;

    logic clk, rst;
    fetch_queue_stage_if #(.WIDTH(16)) bus();

    fetch_queue_stage #(
        .WIDTH(16), .DEPTH(4), .RESET_PC(16'h0000), .HALT_OPCODE(4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // stimulus knobs
    bit          rst_v = 1, redir_v = 0, oready_v = 0, rready_v = 0;
    bit          spur_en = 0, lat_rand = 0;
    logic [15:0] redir_pc_v = 0;
    int          lat_v = 0;
    logic [15:0] halt_addr = 16'h8000;

    // memory responder
    bit          pend = 0;
    logic [15:0] paddr = 0;
    int          dly = 0;

    // reference model
    logic [15:0] m_pc = 0, m_req_pc = 0;
    bit          m_out = 0, m_disc = 0, m_halt = 0;
    logic [31:0] q[$];

    // per-cycle snapshots
    bit          s_req_valid, s_out_valid, s_halted, s_acc;
    logic [15:0] s_addr, s_out_pc, s_pc2;
    logic [15:0] popped[$];
    logic [15:0] acc[$];

    function automatic logic [15:0] memword(input logic [15:0] a);
        if (a == halt_addr) return {4'hF, a[11:0]};
        return {1'b0, a[14:0] ^ 15'h1A5B};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit          fire, spur, e_rv, m_pop, m_acc, m_resp;
        logic [15:0] e_pc, e_instr, e_p2, rdata;
        @(negedge clk);
        fire  = pend && dly == 0;
        spur  = !fire && spur_en && ($urandom_range(7) == 0);
        rdata = fire ? memword(paddr) : 16'($urandom);
        rst                 = rst_v;
        bus.redirect        = redir_v;
        bus.redirect_pc     = redir_pc_v;
        bus.out_ready       = oready_v;
        bus.imem_req_ready  = rready_v;
        bus.imem_resp_valid = fire | spur;
        bus.imem_resp_data  = rdata;
        #1;
        e_rv    = !m_halt && !m_out && !redir_v && q.size() < 4;
        e_pc    = (q.size() != 0) ? q[0][31:16] : 16'h0;
        e_instr = (q.size() != 0) ? q[0][15:0]  : 16'h0;
        e_p2    = e_pc + 16'd2;
        if (!rst_v) begin
            chk("req_valid", bus.imem_req_valid, e_rv);
            if (e_rv) chk("req_addr", bus.imem_req_addr, m_pc);
            chk("out_valid", bus.out_valid, q.size() != 0);
            chk("out_pc", bus.out_pc, e_pc);
            chk("out_instr", bus.out_instr, e_instr);
            chk("out_pc_plus2", bus.out_pc_plus2, e_p2);
            chk("halted", bus.halted, m_halt && !m_out);
        end
        s_req_valid = bus.imem_req_valid;
        s_addr      = bus.imem_req_addr;
        s_out_valid = bus.out_valid;
        s_out_pc    = bus.out_pc;
        s_pc2       = bus.out_pc_plus2;
        s_halted    = bus.halted;
        s_acc       = bus.imem_req_valid && bus.imem_req_ready;
        if (s_acc) acc.push_back(bus.imem_req_addr);
        if (!rst_v && bus.out_valid && bus.out_ready) popped.push_back(bus.out_pc);
        @(posedge clk);
        if (rst_v) begin
            m_pc = 16'h0; m_out = 0; m_disc = 0; m_halt = 0; q.delete();
        end else begin
            m_pop  = q.size() != 0 && oready_v;
            m_acc  = e_rv && rready_v;
            m_resp = (fire || spur) && m_out;
            if (redir_v) begin
                q.delete();
                m_pc   = redir_pc_v;
                m_halt = 0;
                if (m_out) begin
                    m_disc = !m_resp;
                    m_out  = !m_resp;
                end
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_resp) begin
                    m_out = 0;
                    if (m_disc) m_disc = 0;
                    else begin
                        q.push_back({m_req_pc, rdata});
                        if (rdata[15:12] == 4'hF) m_halt = 1;
                    end
                end
                if (m_acc) begin
                    m_out    = 1;
                    m_req_pc = m_pc;
                    m_pc     = m_pc + 16'd2;
                end
            end
        end
        if (fire) pend = 0;
        else if (pend && dly > 0) dly--;
        if (s_acc) begin
            pend  = 1;
            paddr = s_addr;
            dly   = lat_rand ? int'($urandom_range(3)) : lat_v;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_acc(input string name);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!s_acc && k < 40);
        chk(name, s_acc, 1'b1);
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        redir_v = 1; redir_pc_v = pc;
        cycle();
        redir_v = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        rst = 1;
        bus.redirect = 0; bus.redirect_pc = 0; bus.out_ready = 0;
        bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = 0;

        // reset state
        run(2);
        rst_v = 0;
        cycle();
        chk("rst_req_valid", s_req_valid, 1'b1);
        chk("rst_req_addr", s_addr, 16'h0000);
        chk("rst_out_valid", s_out_valid, 1'b0);
        chk("rst_pc_plus2", s_pc2, 16'h0002);
        chk("rst_halted", s_halted, 1'b0);

        // streaming, then backpressure, then drain
        rready_v = 1; oready_v = 1; lat_v = 0;
        popped.delete();
        run(14);
        oready_v = 0;
        run(20);
        chk("bp_req_valid", s_req_valid, 1'b0);
        chk("bp_out_valid", s_out_valid, 1'b1);
        oready_v = 1;
        run(20);
        chk("stream_count", popped.size() >= 10, 1'b1);
        for (int i = 0; i < popped.size(); i++)
            chk("stream_seq", popped[i], 32'(2 * i));

        // redirect with a request still in flight
        lat_v = 3;
        wait_acc("inflight_acc");
        redirect_to(16'h0100);
        popped.delete();
        lat_v = 0;
        run(16);
        chk("redir_first", (popped.size() > 0) ? popped[0] : 16'hDEAD, 16'h0100);

        // redirect coincident with the response
        lat_v = 1;
        wait_acc("coinc_acc");
        cycle();
        redirect_to(16'h0200);
        cycle();
        chk("coinc_req_valid", s_req_valid, 1'b1);
        chk("coinc_req_addr", s_addr, 16'h0200);
        lat_v = 0;

        // halt at 0x0008, then resume by redirect
        halt_addr = 16'h0008;
        redirect_to(16'h0000);
        popped.delete();
        run(25);
        chk("halt_halted", s_halted, 1'b1);
        chk("halt_req_valid", s_req_valid, 1'b0);
        chk("halt_last_pc", (popped.size() > 0) ? popped[popped.size()-1] : 16'hDEAD, 16'h0008);
        redirect_to(16'h0020);
        cycle();
        chk("resume_halted", s_halted, 1'b0);
        chk("resume_req_valid", s_req_valid, 1'b1);
        chk("resume_req_addr", s_addr, 16'h0020);

        // address wrap
        redirect_to(16'hFFFE);
        acc.delete();
        run(8);
        chk("wrap_addr0", (acc.size() > 0) ? acc[0] : 16'hDEAD, 16'hFFFE);
        chk("wrap_addr1", (acc.size() > 1) ? acc[1] : 16'hDEAD, 16'h0000);

        // reset mid-request; late response must be ignored
        lat_v = 2;
        wait_acc("rst_acc");
        rst_v = 1;
        cycle();
        rst_v = 0; rready_v = 0;
        run(3);
        chk("late_out_valid", s_out_valid, 1'b0);
        chk("late_req_valid", s_req_valid, 1'b1);
        chk("late_req_addr", s_addr, 16'h0000);

        // random traffic
        spur_en = 1; lat_rand = 1; halt_addr = 16'h0010;
        for (int i = 0; i < 3000; i++) begin
            rst_v    = $urandom_range(199) == 0;
            redir_v  = $urandom_range(19) == 0;
            redir_pc_v = ($urandom_range(3) == 0) ? 16'(16'hFFF8 + 2 * $urandom_range(3))
                                                  : 16'(2 * $urandom_range(31));
            oready_v = $urandom_range(3) != 0;
            rready_v = $urandom_range(3) != 0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
